// File: rtl/spkr_pkg.sv
// spkr_pkg: shared state type, frame constants and frame builder
// for the speaker DAC sequencer.
package spkr_pkg;

   localparam int FRAME_W  = 24;
   localparam int SAMPLE_W = 12;
   localparam int NUM_CH   = 4;

   localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      GAP
   } state_t;

   function automatic logic [FRAME_W-1:0] build_frame(
      input logic [1:0]          idx,
      input logic [SAMPLE_W-1:0] data
   );
      return {CMD_WRITE_UPDATE, 2'b00, idx, data, 4'b0000};
   endfunction

endpackage

// File: rtl/spkr_spi_shift.sv
// spkr_spi_shift: 24-bit MSB-first SPI shifter with a CLK_DIV
// prescaler; o_done marks the last cycle of bit 0's low phase.
module spkr_spi_shift
   import spkr_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_frame,
   output logic               o_sclk,
   output logic               o_din,
   output logic               o_done
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [FRAME_W-2:0] r_sr;
   logic [4:0]         r_bit;
   logic [DW-1:0]      r_div;
   logic               r_sclk;
   logic               r_din;
   logic               r_active;
   logic               r_armed;

   assign o_sclk = r_sclk;
   assign o_din  = r_din;
   assign o_done = r_active && !r_armed && !r_sclk
                   && (r_div == DIV_LAST) && (r_bit == 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr     <= '0;
         r_bit    <= '0;
         r_div    <= '0;
         r_sclk   <= 1'b0;
         r_din    <= 1'b0;
         r_active <= 1'b0;
         r_armed  <= 1'b0;
      end else if (i_load) begin
         r_sr     <= i_frame[FRAME_W-2:0];
         r_din    <= i_frame[FRAME_W-1];
         r_sclk   <= 1'b0;
         r_bit    <= 5'(FRAME_W - 1);
         r_div    <= '0;
         r_active <= 1'b1;
         r_armed  <= 1'b1;
      end else if (r_active) begin
         // armed = the setup cycle: MSB already on din, sclk still low
         if (r_armed) begin
            r_armed <= 1'b0;
            r_sclk  <= 1'b1;
            r_div   <= '0;
         end else if (r_div != DIV_LAST) begin
            r_div <= r_div + DW'(1);
         end else begin
            r_div <= '0;
            if (r_sclk) begin
               r_sclk <= 1'b0;
            end else if (r_bit == 5'd0) begin
               r_active <= 1'b0;
               r_din    <= 1'b0;
            end else begin
               r_bit  <= r_bit - 5'd1;
               r_din  <= r_sr[FRAME_W-2];
               r_sr   <= {r_sr[FRAME_W-3:0], 1'b0};
               r_sclk <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spkr_dac_sequencer.sv
// spkr_dac_sequencer: four 24-bit SPI write frames per sample set.
// Define SPKR_INVERT_EN to mirror samples about mid-scale on latch.
module spkr_dac_sequencer
   import spkr_pkg::*;
#(
   parameter int CLK_DIV    = 1,
   parameter int GAP_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic [SAMPLE_W-1:0] ch0,
   input  logic [SAMPLE_W-1:0] ch1,
   input  logic [SAMPLE_W-1:0] ch2,
   input  logic [SAMPLE_W-1:0] ch3,
   output logic                dac_sclk,
   output logic                dac_sync_n,
   output logic                dac_din,
   output logic                busy,
   output logic                overrun
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST3 =
      GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
   localparam bit SKIP_GAP3 = (GAP_CYCLES == 1);

   state_t              r_state;
   logic [1:0]          r_idx;
   logic [SAMPLE_W-1:0] r_hold [NUM_CH];
   logic [GW-1:0]       r_gap;
   logic                r_ready;
   logic                r_busy;
   logic                r_sync_n;

   logic               w_done;
   logic               w_last;
   logic               w_gap_end;
   logic               w_load;
   logic [1:0]         w_nidx;
   logic [FRAME_W-1:0] w_frame;

   function automatic logic [SAMPLE_W-1:0] cond(
      input logic [SAMPLE_W-1:0] s
   );
`ifdef SPKR_INVERT_EN
      return 12'hFFF - s;
`else
      return s;
`endif
   endfunction

   // The idle cycle doubles as the final sync_n-high cycle after ch3,
   // so back-to-back sets keep a full gap yet start every set time.
   assign w_last    = (r_idx == 2'd3);
   assign w_nidx    = r_idx + 2'd1;
   assign w_gap_end = (r_state == GAP)
                      && (r_gap == (w_last ? GAP_LAST3 : GAP_LAST));
   assign w_load    = ((r_state == IDLE) && sample_valid)
                      || (w_gap_end && !w_last);
   assign w_frame   = (r_state == IDLE)
                      ? build_frame(2'd0, cond(ch0))
                      : build_frame(w_nidx, r_hold[w_nidx]);

   assign sample_ready = r_ready;
   assign busy         = r_busy;
   assign dac_sync_n   = r_sync_n;
   assign overrun      = sample_valid && !r_ready;

   spkr_spi_shift #(
      .CLK_DIV (CLK_DIV)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_frame (w_frame),
      .o_sclk  (dac_sclk),
      .o_din   (dac_din),
      .o_done  (w_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_idx    <= 2'd0;
         r_gap    <= '0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_sync_n <= 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (sample_valid) begin
                  r_hold[0] <= cond(ch0);
                  r_hold[1] <= cond(ch1);
                  r_hold[2] <= cond(ch2);
                  r_hold[3] <= cond(ch3);
                  r_idx     <= 2'd0;
                  r_state   <= SETUP;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_sync_n  <= 1'b0;
               end
            end
            SETUP: r_state <= SHIFT;
            SHIFT: begin
               if (w_done) begin
                  r_sync_n <= 1'b1;
                  r_gap    <= '0;
                  if (w_last && SKIP_GAP3) begin
                     r_state <= IDLE;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= GAP;
                  end
               end
            end
            GAP: begin
               if (!w_gap_end) begin
                  r_gap <= r_gap + GW'(1);
               end else if (w_last) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_state  <= SETUP;
                  r_idx    <= w_nidx;
                  r_sync_n <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spkr_dac_sequencer.sv
// Bench for spkr_dac_sequencer: default instance plus a
// CLK_DIV=3/GAP_CYCLES=5 instance; frames decoded on sclk falls.
module tb_spkr_dac_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  valid = 2'b00;
   logic [11:0] ch0 = '0;
   logic [11:0] ch1 = '0;
   logic [11:0] ch2 = '0;
   logic [11:0] ch3 = '0;

   logic [1:0] ready_w;
   logic [1:0] sclk_w;
   logic [1:0] sync_w;
   logic [1:0] din_w;
   logic [1:0] busy_w;
   logic [1:0] ovr_w;

   int checks = 0;
   int errors = 0;

   logic [23:0] exp_q [$];

   always #5 clk = ~clk;

   spkr_dac_sequencer #(
      .CLK_DIV    (1),
      .GAP_CYCLES (2)
   ) u_dut0 (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (valid[0]),
      .sample_ready (ready_w[0]),
      .ch0          (ch0),
      .ch1          (ch1),
      .ch2          (ch2),
      .ch3          (ch3),
      .dac_sclk     (sclk_w[0]),
      .dac_sync_n   (sync_w[0]),
      .dac_din      (din_w[0]),
      .busy         (busy_w[0]),
      .overrun      (ovr_w[0])
   );

   spkr_dac_sequencer #(
      .CLK_DIV    (3),
      .GAP_CYCLES (5)
   ) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (valid[1]),
      .sample_ready (ready_w[1]),
      .ch0          (ch0),
      .ch1          (ch1),
      .ch2          (ch2),
      .ch3          (ch3),
      .dac_sclk     (sclk_w[1]),
      .dac_sync_n   (sync_w[1]),
      .dac_din      (din_w[1]),
      .busy         (busy_w[1]),
      .overrun      (ovr_w[1])
   );

   function automatic logic [11:0] exp_d(input logic [11:0] raw);
`ifdef SPKR_INVERT_EN
      return 12'hFFF - raw;
`else
      return raw;
`endif
   endfunction

   function automatic logic [23:0] mk(
      input logic [1:0]  idx,
      input logic [11:0] raw
   );
      return {4'b0011, 2'b00, idx, exp_d(raw), 4'h0};
   endfunction

   // frame decoder: shift din on every sclk 1->0 seen while sync_n low
   logic [23:0] m_sr [2];
   int          m_n  [2];
   logic [1:0]  m_ps = 2'b00;
   logic [23:0] m_want;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst || sync_w[k]) begin
            m_n[k] = 0;
         end else if (m_ps[k] && !sclk_w[k]) begin
            m_sr[k] = {m_sr[k][22:0], din_w[k]};
            m_n[k]++;
            if (m_n[k] == 24) begin
               m_n[k] = 0;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame_unexpected dut%0d: got %h want none",
                           k, m_sr[k]);
               end else begin
                  m_want = exp_q.pop_front();
                  if (m_sr[k] !== m_want) begin
                     errors++;
                     $display("FAIL frame dut%0d: got %h want %h",
                              k, m_sr[k], m_want);
                  end
               end
            end
         end
         m_ps[k] = sclk_w[k];
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_set(input logic [11:0] a, b, c, d);
      exp_q.push_back(mk(2'd0, a));
      exp_q.push_back(mk(2'd1, b));
      exp_q.push_back(mk(2'd2, c));
      exp_q.push_back(mk(2'd3, d));
   endtask

   task automatic drive_ch(input logic [11:0] a, b, c, d);
      ch0 = a;
      ch1 = b;
      ch2 = c;
      ch3 = d;
   endtask

   task automatic check_queue_empty(input string tag);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_frames_left: got %0d want 0",
                  tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic wait_ready(input int k, input int want, input string tag);
      int n;
      n = 1;
      while (ready_w[k] !== 1'b1 && n < 2000) begin
         cyc();
         n++;
      end
      checks++;
      if (n != want) begin
         errors++;
         $display("FAIL %s_ready_cycle: got %0d want %0d", tag, n, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid = 2'b00;
      repeat (3) cyc();
      for (int k = 0; k < 2; k++) begin
         checks += 6;
         if (ready_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready%0d: got %b want 1", k, ready_w[k]);
         end
         if (busy_w[k] !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy%0d: got %b want 0", k, busy_w[k]);
         end
         if (sclk_w[k] !== 1'b0) begin
            errors++;
            $display("FAIL rst_sclk%0d: got %b want 0", k, sclk_w[k]);
         end
         if (sync_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL rst_sync%0d: got %b want 1", k, sync_w[k]);
         end
         if (din_w[k] !== 1'b0) begin
            errors++;
            $display("FAIL rst_din%0d: got %b want 0", k, din_w[k]);
         end
         if (ovr_w[k] !== 1'b0) begin
            errors++;
            $display("FAIL rst_ovr%0d: got %b want 0", k, ovr_w[k]);
         end
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic run_set(
      input logic [11:0] a, b, c, d,
      input string tag
   );
      push_set(a, b, c, d);
      drive_ch(a, b, c, d);
      valid[0] = 1'b1;
      cyc();
      valid[0] = 1'b0;
      checks += 3;
      if (sync_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL %s_sync_latency: got %b want 0", tag, sync_w[0]);
      end
      if (busy_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy: got %b want 1", tag, busy_w[0]);
      end
      if (ready_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL %s_ready_low: got %b want 0", tag, ready_w[0]);
      end
      wait_ready(0, 204, tag);
      cyc();
      check_queue_empty(tag);
   endtask

   task automatic test_basic();
      run_set(12'h123, 12'h456, 12'h789, 12'hABC, "basic");
   endtask

   task automatic test_boundary();
      run_set(12'hFFF, 12'h000, 12'h800, 12'h7FF, "bound");
   endtask

   task automatic test_hold_stable();
      push_set(12'h0F1, 12'h2E3, 12'h4D5, 12'h6C7);
      drive_ch(12'h0F1, 12'h2E3, 12'h4D5, 12'h6C7);
      valid[0] = 1'b1;
      cyc();
      valid[0] = 1'b0;
      drive_ch(12'hAAA, 12'h555, 12'h0FF, 12'hF00);
      repeat (60) cyc();
      drive_ch(12'h111, 12'h222, 12'h333, 12'h444);
      wait_ready(0, 204 - 60, "hold");
      cyc();
      check_queue_empty("hold");
   endtask

   task automatic test_back_to_back();
      int  acc;
      bit  want_rdy;
      acc = 0;
      push_set(12'h321, 12'h654, 12'h987, 12'hCBA);
      push_set(12'h321, 12'h654, 12'h987, 12'hCBA);
      drive_ch(12'h321, 12'h654, 12'h987, 12'hCBA);
      valid[0] = 1'b1;
      for (int c = 0; c < 300; c++) begin
         want_rdy = (c == 0) || (c == 204);
         checks += 2;
         if (ready_w[0] !== want_rdy) begin
            errors++;
            $display("FAIL b2b_ready c%0d: got %b want %b",
                     c, ready_w[0], want_rdy);
         end
         if (ovr_w[0] !== !want_rdy) begin
            errors++;
            $display("FAIL b2b_overrun c%0d: got %b want %b",
                     c, ovr_w[0], !want_rdy);
         end
         if (ready_w[0] === 1'b1) acc++;
         cyc();
      end
      valid[0] = 1'b0;
      checks++;
      if (acc != 2) begin
         errors++;
         $display("FAIL b2b_accepts: got %0d want 2", acc);
      end
      wait_ready(0, 408 - 299, "b2b");
      cyc();
      check_queue_empty("b2b");
   endtask

   task automatic test_reset_midframe();
      int rises;
      logic ps;
      exp_q.push_back(mk(2'd0, 12'h5A5));
      exp_q.push_back(mk(2'd1, 12'hA5A));
      drive_ch(12'h5A5, 12'hA5A, 12'h3C3, 12'hC3C);
      valid[0] = 1'b1;
      cyc();
      valid[0] = 1'b0;
      repeat (129) cyc();
      checks++;
      if (sclk_w[0] !== 1'b1 || sync_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit10: got sclk=%b sync=%b want 1 0",
                  sclk_w[0], sync_w[0]);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks += 5;
      if (sync_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_sync: got %b want 1", sync_w[0]);
      end
      if (sclk_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_sclk: got %b want 0", sclk_w[0]);
      end
      if (din_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_din: got %b want 0", din_w[0]);
      end
      if (ready_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_ready: got %b want 1", ready_w[0]);
      end
      if (busy_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_busy: got %b want 0", busy_w[0]);
      end
      rises = 0;
      ps = sclk_w[0];
      repeat (80) begin
         cyc();
         if (sclk_w[0] && !ps) rises++;
         ps = sclk_w[0];
      end
      checks++;
      if (rises != 0) begin
         errors++;
         $display("FAIL mid_sclk_edges: got %0d want 0", rises);
      end
      check_queue_empty("mid");
   endtask

   task automatic test_clkdiv3();
      int  c, hr, lr, gr;
      bit  in_low, seen;
      hr = 0;
      lr = 0;
      gr = 0;
      in_low = 0;
      seen = 0;
      push_set(12'hFA0, 12'h05F, 12'h9C3, 12'h36E);
      drive_ch(12'hFA0, 12'h05F, 12'h9C3, 12'h36E);
      valid[1] = 1'b1;
      cyc();
      valid[1] = 1'b0;
      c = 1;
      while (ready_w[1] !== 1'b1 && c < 2000) begin
         if (sclk_w[1]) begin
            if (in_low) begin
               checks++;
               if (lr != 3) begin
                  errors++;
                  $display("FAIL div3_low c%0d: got %0d want 3", c, lr);
               end
            end
            in_low = 0;
            lr = 0;
            hr++;
         end else begin
            if (hr > 0) begin
               checks++;
               if (hr != 3) begin
                  errors++;
                  $display("FAIL div3_high c%0d: got %0d want 3", c, hr);
               end
               hr = 0;
               in_low = 1;
               lr = 0;
            end
            if (sync_w[1]) begin
               if (in_low) begin
                  checks++;
                  if (lr != 3) begin
                     errors++;
                     $display("FAIL div3_lastlow c%0d: got %0d want 3",
                              c, lr);
                  end
                  in_low = 0;
                  lr = 0;
               end
               gr++;
            end else begin
               if (in_low) lr++;
               if (gr > 0 && seen) begin
                  checks++;
                  if (gr != 5) begin
                     errors++;
                     $display("FAIL div3_gap c%0d: got %0d want 5", c, gr);
                  end
               end
               gr = 0;
               seen = 1;
            end
         end
         cyc();
         c++;
      end
      checks++;
      if (c != 600) begin
         errors++;
         $display("FAIL div3_set_time: got %0d want 600", c);
      end
      cyc();
      check_queue_empty("div3");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_hold_stable();
      test_back_to_back();
      test_reset_midframe();
      test_clkdiv3();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
